trap_sequencer: RTL and testbench

Sequences every privilege-changing event into the CSR register file: synchronous exceptions, enabled M/S interrupts, and MRET/SRET/URET. It arbitrates between simultaneous sources and drains the pipeline with a handshake. It then presents a single-cycle commit (`exception_pending`, `cause`, `pc_exc`, `x_ret`) to the CSR file, captures the CSR-supplied target (`epc`), and issues one redirect to the front end. It sits between the execute stage, the CSR register file and the fetch unit.

---
 rtl/trap_sequencer.sv | 157 +++++++++++++++
 tb/tb_trap_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Trap sequencer: arbitrates exceptions, interrupts and xRET, drains the pipeline,
// issues a one-cycle commit to the CSR file and a single front-end redirect.
module trap_sequencer #(
    parameter int XLEN      = 32,
    parameter int DRAIN_MAX = 15
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            exc_valid,
    input  logic [4:0]      exc_code,
    input  logic [XLEN-1:0] exc_pc,
    input  logic            ret_valid,
    input  logic [1:0]      ret_kind,
    input  logic [XLEN-1:0] irq_pc,
    input  logic [1:0]      current_mode,
    input  logic            m_interrupt,
    input  logic            m_timer,
    input  logic            s_interrupt,
    input  logic            s_timer,
    input  logic            m_eie,
    input  logic            m_tie,
    input  logic            s_eie,
    input  logic            s_tie,
    input  logic [XLEN-1:0] epc,
    output logic            drain_req,
    input  logic            drain_done,
    output logic            exception_pending,
    output logic [XLEN-1:0] cause,
    output logic [XLEN-1:0] pc_exc,
    output logic            m_ret,
    output logic            s_ret,
    output logic            u_ret,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            busy,
    output logic            drain_timeout
);

    typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;
    typedef enum logic [1:0] {KIND_EXC, KIND_RET, KIND_IRQ} kind_t;

    localparam logic [4:0] CODE_MEI   = 5'd11;
    localparam logic [4:0] CODE_MTI   = 5'd7;
    localparam logic [4:0] CODE_SEI   = 5'd9;
    localparam logic [4:0] CODE_STI   = 5'd5;
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);

    state_t          state, state_nxt;
    kind_t           sel_kind, kind_q;
    logic            sel_valid;
    logic [XLEN-1:0] sel_cause, sel_pc;
    logic [XLEN-1:0] cause_q, pc_q;
    logic [1:0]      ret_kind_q;
    logic [7:0]      drain_cnt;
    logic            s_irq_en;

    // Supervisor interrupts never preempt machine mode.
    assign s_irq_en = (current_mode != 2'b11);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel_valid = 1'b1;
        sel_kind  = KIND_EXC;
        sel_cause = '0;
        sel_pc    = '0;
        if (exc_valid) begin
            sel_cause[4:0] = exc_code;
            sel_pc         = exc_pc;
        end else if (ret_valid && ret_kind != 2'b00) begin
            sel_kind = KIND_RET;
        end else begin
            sel_kind          = KIND_IRQ;
            sel_cause[XLEN-1] = 1'b1;
            sel_pc            = irq_pc;
            if (m_interrupt && m_eie)                  sel_cause[4:0] = CODE_MEI;
            else if (m_timer && m_tie)                 sel_cause[4:0] = CODE_MTI;
            else if (s_irq_en && s_interrupt && s_eie) sel_cause[4:0] = CODE_SEI;
            else if (s_irq_en && s_timer && s_tie)     sel_cause[4:0] = CODE_STI;
            else begin
                sel_valid = 1'b0;
                sel_cause = '0;
                sel_pc    = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        drain_req         = 1'b0;
        exception_pending = 1'b0;
        cause             = '0;
        pc_exc            = '0;
        m_ret             = 1'b0;
        s_ret             = 1'b0;
        u_ret             = 1'b0;
        redirect_valid    = 1'b0;
        busy              = (state != IDLE);
        case (state)
            IDLE: if (sel_valid) state_nxt = DRAIN;
            DRAIN: begin
                drain_req = 1'b1;
                if (drain_done || drain_cnt == DRAIN_LAST) state_nxt = COMMIT;
            end
            COMMIT: begin
                exception_pending = 1'b1;
                cause             = cause_q;
                pc_exc            = pc_q;
                if (kind_q == KIND_RET) begin
                    m_ret = (ret_kind_q == 2'b11);
                    s_ret = (ret_kind_q == 2'b10);
                    u_ret = (ret_kind_q == 2'b01);
                end
                state_nxt = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                if (redirect_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the event latches are reset too, so a reset mid-flight leaves nothing stale to commit.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            kind_q        <= KIND_EXC;
            cause_q       <= '0;
            pc_q          <= '0;
            ret_kind_q    <= '0;
            drain_cnt     <= '0;
            redirect_pc   <= '0;
            drain_timeout <= 1'b0;
        end else begin
            if (state == IDLE && sel_valid) begin
                kind_q     <= sel_kind;
                cause_q    <= sel_cause;
                pc_q       <= sel_pc;
                ret_kind_q <= ret_kind;
                drain_cnt  <= '0;
            end else if (state == DRAIN) begin
                drain_cnt <= drain_cnt + 8'd1;
            end
            if (state == DRAIN && !drain_done && drain_cnt == DRAIN_LAST)
                drain_timeout <= 1'b1;
            if (state == COMMIT)
                redirect_pc <= epc;
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Randomized transaction-level bench for trap_sequencer against a priority/latency model.
module tb_trap_sequencer;

    localparam int XLEN      = 32;
    localparam int DRAIN_MAX = 15;

    logic            clk, nrst;
    logic            exc_valid, ret_valid, drain_done, redirect_ready;
    logic [4:0]      exc_code;
    logic [1:0]      ret_kind, current_mode;
    logic [XLEN-1:0] exc_pc, irq_pc, epc;
    logic            m_interrupt, m_timer, s_interrupt, s_timer;
    logic            m_eie, m_tie, s_eie, s_tie;
    logic            drain_req, exception_pending, m_ret, s_ret, u_ret;
    logic            redirect_valid, busy, drain_timeout;
    logic [XLEN-1:0] cause, pc_exc, redirect_pc;

    trap_sequencer #(.XLEN(XLEN), .DRAIN_MAX(DRAIN_MAX)) dut (
        .clk(clk), .nrst(nrst),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
        .ret_valid(ret_valid), .ret_kind(ret_kind), .irq_pc(irq_pc),
        .current_mode(current_mode),
        .m_interrupt(m_interrupt), .m_timer(m_timer),
        .s_interrupt(s_interrupt), .s_timer(s_timer),
        .m_eie(m_eie), .m_tie(m_tie), .s_eie(s_eie), .s_tie(s_tie),
        .epc(epc), .drain_req(drain_req), .drain_done(drain_done),
        .exception_pending(exception_pending), .cause(cause), .pc_exc(pc_exc),
        .m_ret(m_ret), .s_ret(s_ret), .u_ret(u_ret),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .busy(busy), .drain_timeout(drain_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        exc_v;
        logic [4:0]  code;
        logic [31:0] exc_pc;
        logic        ret_v;
        logic [1:0]  rk;
        logic [31:0] irq_pc;
        logic [1:0]  mode;
        logic [3:0]  pend;  // {m_interrupt, m_timer, s_interrupt, s_timer}
        logic [3:0]  en;    // {m_eie, m_tie, s_eie, s_tie}
        logic [31:0] epc;
    } stim_t;

    int checks   = 0;
    int failures = 0;
    bit to_model = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: which event is taken and what the CSR file should see.
    function automatic void model(input stim_t s, output bit v, output logic [31:0] c,
                                  output logic [31:0] pc, output logic [2:0] rets);
        v = 1'b1; c = '0; pc = '0; rets = 3'b000;
        if (s.exc_v) begin
            c  = {27'd0, s.code};
            pc = s.exc_pc;
        end else if (s.ret_v && s.rk != 2'b00) begin
            rets = (s.rk == 2'b11) ? 3'b100 : (s.rk == 2'b10) ? 3'b010 : 3'b001;
        end else begin
            v = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!v && s.pend[3-i] && s.en[3-i] && (i < 2 || s.mode != 2'b11)) begin
                    v  = 1'b1;
                    pc = s.irq_pc;
                    case (i)
                        0:       c = 32'h8000_000B;
                        1:       c = 32'h8000_0007;
                        2:       c = 32'h8000_0009;
                        default: c = 32'h8000_0005;
                    endcase
                end
            end
        end
    endfunction

    task automatic apply(input stim_t s);
        exc_valid = s.exc_v; exc_code = s.code; exc_pc = s.exc_pc;
        ret_valid = s.ret_v; ret_kind = s.rk;   irq_pc = s.irq_pc;
        current_mode = s.mode; epc = s.epc;
        {m_interrupt, m_timer, s_interrupt, s_timer} = s.pend;
        {m_eie, m_tie, s_eie, s_tie} = s.en;
    endtask

    task automatic clear_inputs();
        exc_valid = 1'b0; ret_valid = 1'b0; drain_done = 1'b0; redirect_ready = 1'b0;
        {m_interrupt, m_timer, s_interrupt, s_timer} = 4'b0;
    endtask

    function automatic stim_t blank();
        stim_t s;
        s.exc_v = 0; s.code = 0; s.exc_pc = 0; s.ret_v = 0; s.rk = 0;
        s.irq_pc = 0; s.mode = 2'b00; s.pend = 0; s.en = 0; s.epc = 0;
        return s;
    endfunction

    // One event: d = DRAIN cycles before drain_done rises, hold = extra REDIRECT cycles without ready.
    task automatic run_event(input stim_t s, input int d, input int hold);
        bit          v, got;
        logic [31:0] ec, epc_exp;
        logic [2:0]  er;
        int          n, exp_n;
        model(s, v, ec, epc_exp, er);
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        apply(s);
        drain_done = 1'b0;
        redirect_ready = 1'b0;
        @(negedge clk);
        if (!v) begin
            check("no_event_busy", 64'(busy), 64'd0);
            check("no_event_commit", 64'(exception_pending), 64'd0);
            clear_inputs();
            return;
        end
        check("drain_entry", 64'({busy, drain_req}), 64'b11);
        n = 0; got = 0;
        for (int i = 0; i < DRAIN_MAX + 5; i++) begin
            if (exception_pending) begin
                got = 1;
                break;
            end
            check("drain_req_high", 64'(drain_req), 64'd1);
            drain_done = (n >= d);
            n++;
            // A latched interrupt must survive its source going away.
            if (n == 1 && !s.exc_v && $urandom_range(0, 1) == 1)
                {m_interrupt, m_timer, s_interrupt, s_timer} = 4'b0;
            @(negedge clk);
        end
        exp_n = (d < DRAIN_MAX) ? d + 1 : DRAIN_MAX;
        if (d >= DRAIN_MAX) to_model = 1;
        check("commit_seen", 64'(got), 64'd1);
        check("drain_cycles", 64'(n), 64'(exp_n));
        check("commit_drain_req", 64'(drain_req), 64'd0);
        check("commit_cause", 64'(cause), 64'(ec));
        check("commit_pc_exc", 64'(pc_exc), 64'(epc_exp));
        check("commit_rets", 64'({m_ret, s_ret, u_ret}), 64'(er));
        check("commit_timeout", 64'(drain_timeout), 64'(to_model));
        @(negedge clk);
        check("strobe_single", 64'(exception_pending), 64'd0);
        check("rets_low", 64'({m_ret, s_ret, u_ret}), 64'd0);
        check("redir_valid", 64'(redirect_valid), 64'd1);
        check("redir_pc", 64'(redirect_pc), 64'(s.epc));
        epc = ~s.epc;  // the captured target must not follow epc afterwards
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("redir_hold_valid", 64'(redirect_valid), 64'd1);
            check("redir_hold_pc", 64'(redirect_pc), 64'(s.epc));
        end
        redirect_ready = 1'b1;
        @(negedge clk);
        check("back_idle", 64'({busy, redirect_valid}), 64'd0);
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        nrst = 1'b0;
        s = blank();
        apply(s);
        clear_inputs();
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'({drain_req, exception_pending, redirect_valid, busy, drain_timeout}), 64'd0);
        check("reset_redirect_pc", 64'(redirect_pc), 64'd0);
        nrst = 1'b1;

        // Exception example.
        s = blank(); s.exc_v = 1; s.code = 5'd2; s.exc_pc = 32'h100; s.epc = 32'h80;
        run_event(s, 0, 0);
        // Interrupt priority, then the next level once m_timer drops.
        s = blank(); s.mode = 2'b01; s.irq_pc = 32'h2000; s.pend = 4'b0110; s.en = 4'b0110; s.epc = 32'h44;
        run_event(s, 1, 0);
        s.pend = 4'b0010;
        run_event(s, 0, 1);
        // S interrupts masked in M mode.
        s = blank(); s.mode = 2'b11; s.pend = 4'b0011; s.en = 4'b0011;
        run_event(s, 0, 0);
        // MRET with a held-off redirect; illegal ret_kind is ignored.
        s = blank(); s.ret_v = 1; s.rk = 2'b11; s.epc = 32'h400;
        run_event(s, 0, 3);
        s = blank(); s.ret_v = 1; s.rk = 2'b00;
        run_event(s, 0, 0);
        // Exception beats a simultaneous SRET; the SRET follows.
        s = blank(); s.exc_v = 1; s.code = 5'd13; s.exc_pc = 32'h3000; s.ret_v = 1; s.rk = 2'b10; s.epc = 32'h500;
        run_event(s, 2, 0);
        s.exc_v = 0;
        run_event(s, 0, 0);
        // Forced commit with drain_done stuck low.
        s = blank(); s.exc_v = 1; s.code = 5'd4; s.exc_pc = 32'hABC; s.epc = 32'h900;
        run_event(s, 1000, 1);
        check("timeout_sticky", 64'(drain_timeout), 64'd1);

        for (int t = 0; t < 60; t++) begin
            s.exc_v  = ($urandom_range(0, 3) == 0);
            s.code   = 5'($urandom);
            s.exc_pc = $urandom;
            s.ret_v  = ($urandom_range(0, 2) == 0);
            s.rk     = 2'($urandom);
            s.irq_pc = $urandom;
            s.mode   = 2'($urandom);
            s.pend   = 4'($urandom);
            s.en     = 4'($urandom);
            s.epc    = $urandom;
            run_event(s, ($urandom_range(0, 7) == 0) ? $urandom_range(DRAIN_MAX - 2, DRAIN_MAX + 2)
                                                     : $urandom_range(0, 3),
                      $urandom_range(0, 3));
        end

        // Reset mid-DRAIN drops the event and clears the sticky timeout.
        s = blank(); s.exc_v = 1; s.code = 5'd1; s.exc_pc = 32'h77; s.epc = 32'h66;
        @(negedge clk);
        apply(s);
        drain_done = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_drain", 64'(drain_req), 64'd1);
        nrst = 1'b0;
        #1;
        check("midreset_outputs", 64'({drain_req, exception_pending, redirect_valid, busy, drain_timeout}), 64'd0);
        check("midreset_cause", 64'(cause), 64'd0);
        check("midreset_redirect_pc", 64'(redirect_pc), 64'd0);
        to_model = 0;
        clear_inputs();
        @(negedge clk);
        nrst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_reset_quiet", 64'({busy, exception_pending, redirect_valid}), 64'd0);
        end
        s = blank(); s.ret_v = 1; s.rk = 2'b01; s.epc = 32'h1234;
        run_event(s, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
